// File: rtl/load_store_unit.sv
// Load/store unit: takes one load or store request and runs the memory handshake.
// It produces byte enables and lane-shifted store data, and returns extended load data.
// The optional macro LSU_MISALIGNED_SPLIT_EN turns a word-crossing access into two word accesses.
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [2:0]              req_funct3,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    output logic                    resp_err,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_resp
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam logic [2*LANES-1:0] BE_ONE = 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC1 = 2'd1;
`ifdef LSU_MISALIGNED_SPLIT_EN
    localparam logic [1:0] S_ACC2 = 2'd2;
`endif
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]            state_q, state_d;
    logic                  write_q, write_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [OFF_W-1:0]      off_q, off_d;
    logic [ADDR_WIDTH-1:0] addr1_q, addr1_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
`ifdef LSU_MISALIGNED_SPLIT_EN
    logic                    split_q, split_d;
    logic [2*LANES-1:0]      be_q, be_d;
    logic [2*DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata1_q, rdata1_d;
`else
    logic [LANES-1:0]        be_q, be_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
`endif

    // Request decode: masks are built twice as wide so the overflow lanes form the second access.
    logic [OFF_W-1:0]        req_off;
    logic [3:0]              req_size;
    logic [2*LANES-1:0]      req_be_wide;
    logic [2*DATA_WIDTH-1:0] req_wdata_wide;
    logic                    req_split;
    logic                    req_illegal;

    assign req_off        = req_addr[OFF_W-1:0];
    assign req_size       = 4'd1 << req_funct3[1:0];
    assign req_be_wide    = ((BE_ONE << req_size) - BE_ONE) << req_off;
    assign req_wdata_wide = {{DATA_WIDTH{1'b0}}, req_wdata} << {req_off, 3'b000};
    assign req_split      = (5'(req_off) + 5'(req_size)) > 5'(LANES);

    always_comb begin
        req_illegal = ({1'b0, req_size} > 5'(LANES))
                   || (req_write && req_funct3[2])
                   || (!req_write && (req_funct3 == 3'b111));
`ifndef LSU_MISALIGNED_SPLIT_EN
        req_illegal = req_illegal || req_split;
`endif
    end

    // Load extension: align the addressed bytes to bit 0, keep size bytes, then extend.
    logic [DATA_WIDTH-1:0] rd_low;
    logic [DATA_WIDTH-1:0] rd_keep;
    logic [DATA_WIDTH-1:0] rd_ext;
    logic [3:0]            size_q;
    logic                  rd_sign;

`ifdef LSU_MISALIGNED_SPLIT_EN
    logic [2*DATA_WIDTH-1:0] rd_pair;
    assign rd_pair = (state_q == S_ACC2) ? {mem_rdata, rdata1_q}
                                         : {{DATA_WIDTH{1'b0}}, mem_rdata};
    assign rd_low  = DATA_WIDTH'(rd_pair >> {off_q, 3'b000});
`else
    assign rd_low  = mem_rdata >> {off_q, 3'b000};
`endif

    assign size_q = 4'd1 << funct3_q[1:0];

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_keep
            assign rd_keep[8*gi +: 8] = {8{4'(gi) < size_q}};
        end
    endgenerate

    always_comb begin
        case (funct3_q[1:0])
            2'd0:    rd_sign = rd_low[7];
            2'd1:    rd_sign = rd_low[15];
            2'd2:    rd_sign = rd_low[31];
            default: rd_sign = rd_low[DATA_WIDTH-1];
        endcase
    end

    assign rd_ext = (rd_low & rd_keep) | ({DATA_WIDTH{rd_sign & ~funct3_q[2]}} & ~rd_keep);

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        addr1_d  = addr1_q;
        err_d    = err_q;
        result_d = result_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
`ifdef LSU_MISALIGNED_SPLIT_EN
        split_d  = split_q;
        rdata1_d = rdata1_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    write_d  = req_write;
                    funct3_d = req_funct3;
                    off_d    = req_off;
                    addr1_d  = {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                    err_d    = req_illegal;
                    result_d = '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
                    split_d  = req_split && !req_illegal;
                    be_d     = req_illegal ? '0 : req_be_wide;
                    wdata_d  = (req_write && !req_illegal) ? req_wdata_wide : '0;
`else
                    be_d     = req_illegal ? '0 : req_be_wide[LANES-1:0];
                    wdata_d  = (req_write && !req_illegal) ? req_wdata_wide[DATA_WIDTH-1:0] : '0;
`endif
                    state_d  = req_illegal ? S_DONE : S_ACC1;
                end
            end
            S_ACC1: begin
                if (mem_resp) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                    if (split_q) begin
                        rdata1_d = mem_rdata;
                        state_d  = S_ACC2;
                    end else begin
                        result_d = rd_ext;
                        state_d  = S_DONE;
                    end
`else
                    result_d = rd_ext;
                    state_d  = S_DONE;
`endif
                end
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            S_ACC2: begin
                if (mem_resp) begin
                    result_d = rd_ext;
                    state_d  = S_DONE;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            write_q  <= 1'b0;
            funct3_q <= '0;
            off_q    <= '0;
            addr1_q  <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            split_q  <= 1'b0;
            rdata1_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            addr1_q  <= addr1_d;
            err_q    <= err_d;
            result_q <= result_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
`ifdef LSU_MISALIGNED_SPLIT_EN
            split_q  <= split_d;
            rdata1_q <= rdata1_d;
`endif
        end
    end

    // Memory-side outputs are pure functions of the held state, so they stay put until mem_resp.
    always_comb begin
        req_ready       = (state_q == S_IDLE) && !rst;
        resp_valid      = (state_q == S_DONE);
        resp_err        = (state_q == S_DONE) && err_q;
        resp_rdata      = ((state_q == S_DONE) && !err_q && !write_q) ? result_q : '0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = '0;
        mem_byte_enable = '0;
        mem_wdata       = '0;
        if (state_q == S_ACC1) begin
            mem_read        = !write_q;
            mem_write       = write_q;
            mem_address     = addr1_q;
            mem_byte_enable = be_q[LANES-1:0];
            mem_wdata       = wdata_q[DATA_WIDTH-1:0];
        end
`ifdef LSU_MISALIGNED_SPLIT_EN
        if (state_q == S_ACC2) begin
            mem_read        = !write_q;
            mem_write       = write_q;
            mem_address     = addr1_q + ADDR_WIDTH'(LANES);
            mem_byte_enable = be_q[2*LANES-1:LANES];
            mem_wdata       = wdata_q[2*DATA_WIDTH-1:DATA_WIDTH];
        end
`endif
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: table of load/store vectors with a responding memory model,
// a response scoreboard, plus reset, stray-response and 64-bit sequences.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_address;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_resp;

    logic        w_req_valid, w_req_ready, w_req_write;
    logic [2:0]  w_req_funct3;
    logic [31:0] w_req_addr;
    logic [63:0] w_req_wdata;
    logic        w_resp_valid, w_resp_err;
    logic [63:0] w_resp_rdata;
    logic        w_mem_read, w_mem_write;
    logic [31:0] w_mem_address;
    logic [7:0]  w_mem_byte_enable;
    logic [63:0] w_mem_wdata, w_mem_rdata;
    logic        w_mem_resp;

    int pass_cnt  = 0;
    int total_cnt = 0;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    load_store_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut64 (
        .clk(clk), .rst(rst),
        .req_valid(w_req_valid), .req_ready(w_req_ready), .req_write(w_req_write),
        .req_funct3(w_req_funct3), .req_addr(w_req_addr), .req_wdata(w_req_wdata),
        .resp_valid(w_resp_valid), .resp_err(w_resp_err), .resp_rdata(w_resp_rdata),
        .mem_read(w_mem_read), .mem_write(w_mem_write), .mem_address(w_mem_address),
        .mem_byte_enable(w_mem_byte_enable), .mem_wdata(w_mem_wdata),
        .mem_rdata(w_mem_rdata), .mem_resp(w_mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        int          delay;
        logic        err;
        logic        split;
        logic [31:0] addr1;
        logic [3:0]  be1;
        logic [31:0] wd1;
        logic [31:0] addr2;
        logic [3:0]  be2;
        logic [31:0] wd2;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    localparam int NUM_VECS = 15;
    vec_t vecs [NUM_VECS];
    exp_t sb_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard: every completion pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        exp_t e;
        if (resp_valid) begin
            if (sb_q.size() == 0) begin
                total_cnt++;
                $display("FAIL sb_unexpected: resp_valid with no outstanding request");
            end else begin
                e = sb_q.pop_front();
                check("sb_resp_err", resp_err, e.err);
                check("sb_resp_rdata", resp_rdata, e.rdata);
            end
        end
    end

    task automatic do_access(input int idx, input int ph, input logic wr, input logic [31:0] a,
                             input logic [3:0] be, input logic [31:0] wd, input logic [31:0] rd,
                             input int dly);
        for (int i = 0; i < dly; i++) begin
            check($sformatf("v%0d_acc%0d_c%0d_ctl", idx, ph, i),
                  {req_ready, mem_read, mem_write, mem_address, mem_byte_enable},
                  {1'b0, !wr, wr, a, be});
            if (wr) check($sformatf("v%0d_acc%0d_c%0d_wdata", idx, ph, i), mem_wdata, wd);
            if (i == dly - 1) begin
                mem_resp  = 1'b1;
                mem_rdata = rd;
            end
            @(negedge clk);
            mem_resp  = 1'b0;
            mem_rdata = '0;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        check($sformatf("v%0d_ready", idx), req_ready, 1);
        req_valid  = 1'b1;
        req_write  = v.write;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        sb_q.push_back({v.err, v.exp_rdata});
        @(negedge clk);
        req_valid = 1'b0;
        if (v.err) begin
            check($sformatf("v%0d_nostrobe", idx), {mem_read, mem_write}, 2'b00);
        end else begin
            do_access(idx, 1, v.write, v.addr1, v.be1, v.wd1, v.rdata1, v.delay);
            if (v.split) do_access(idx, 2, v.write, v.addr2, v.be2, v.wd2, v.rdata2, v.delay);
        end
        check($sformatf("v%0d_resp_valid", idx), {resp_valid, mem_read, mem_write}, 3'b100);
        @(negedge clk);
        check($sformatf("v%0d_resp_pulse", idx), {resp_valid, req_ready}, 2'b01);
        $display("txn %0d: %s f3=%0d addr=0x%08h err=%0d rdata=0x%08h",
                 idx, v.write ? "store" : "load ", v.f3, v.addr, v.err, v.exp_rdata);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //         wr    f3      addr          wdata         rdata1        rdata2       dly err   split addr1         be1      wd1           addr2  be2      wd2    exp_rdata
        vecs[0]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_1234, 32'h0,       1, 1'b0, 1'b0, 32'h0000_0100, 4'b1000, 32'h0,        32'h0, 4'b0000, 32'h0, 32'hFFFF_FF80};
        vecs[1]  = '{1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_1234, 32'h0,       2, 1'b0, 1'b0, 32'h0000_0100, 4'b1000, 32'h0,        32'h0, 4'b0000, 32'h0, 32'h0000_0080};
        vecs[2]  = '{1'b1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 32'h0,        32'h0,       1, 1'b0, 1'b0, 32'h0000_0200, 4'b1100, 32'hABCD_0000, 32'h0, 4'b0000, 32'h0, 32'h0};
        vecs[3]  = '{1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF_1234, 32'h0,       5, 1'b0, 1'b0, 32'h0000_0100, 4'b1100, 32'h0,        32'h0, 4'b0000, 32'h0, 32'hFFFF_80FF};
        vecs[4]  = '{1'b0, 3'b101, 32'h0000_0100, 32'h0,        32'h80FF_1234, 32'h0,       3, 1'b0, 1'b0, 32'h0000_0100, 4'b0011, 32'h0,        32'h0, 4'b0000, 32'h0, 32'h0000_1234};
        vecs[5]  = '{1'b0, 3'b010, 32'h0000_0104, 32'h0,        32'hDEAD_BEEF, 32'h0,       1, 1'b0, 1'b0, 32'h0000_0104, 4'b1111, 32'h0,        32'h0, 4'b0000, 32'h0, 32'hDEAD_BEEF};
        vecs[6]  = '{1'b1, 3'b000, 32'h0000_0301, 32'h1234_5678, 32'h0,        32'h0,       2, 1'b0, 1'b0, 32'h0000_0300, 4'b0010, 32'h3456_7800, 32'h0, 4'b0000, 32'h0, 32'h0};
        vecs[7]  = '{1'b1, 3'b010, 32'h0000_0400, 32'hCAFE_F00D, 32'h0,        32'h0,       4, 1'b0, 1'b0, 32'h0000_0400, 4'b1111, 32'hCAFE_F00D, 32'h0, 4'b0000, 32'h0, 32'h0};
        vecs[8]  = '{1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        32'h0,       1, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h0,        32'h0, 4'b0000, 32'h0, 32'h0};
        vecs[9]  = '{1'b1, 3'b100, 32'h0000_0000, 32'h0000_00AA, 32'h0,        32'h0,       1, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h0,        32'h0, 4'b0000, 32'h0, 32'h0};
        vecs[10] = '{1'b0, 3'b111, 32'h0000_0010, 32'h0,        32'h0,        32'h0,       1, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h0,        32'h0, 4'b0000, 32'h0, 32'h0};
        vecs[14] = '{1'b0, 3'b101, 32'h0000_0001, 32'h0,        32'h00AB_CD00, 32'h0,       2, 1'b0, 1'b0, 32'h0000_0000, 4'b0110, 32'h0,        32'h0, 4'b0000, 32'h0, 32'h0000_ABCD};
`ifdef LSU_MISALIGNED_SPLIT_EN
        vecs[11] = '{1'b0, 3'b010, 32'h0000_0006, 32'h0,        32'h5566_0000, 32'h0000_7788, 1, 1'b0, 1'b1, 32'h0000_0004, 4'b1100, 32'h0,      32'h0000_0008, 4'b0011, 32'h0, 32'h7788_5566};
        vecs[12] = '{1'b1, 3'b010, 32'hFFFF_FFFE, 32'h1122_3344, 32'h0,        32'h0,         2, 1'b0, 1'b1, 32'hFFFF_FFFC, 4'b1100, 32'h3344_0000, 32'h0000_0000, 4'b0011, 32'h0000_1122, 32'h0};
        vecs[13] = '{1'b0, 3'b001, 32'h0000_0003, 32'h0,        32'hAB00_0000, 32'h0000_00CD, 3, 1'b0, 1'b1, 32'h0000_0000, 4'b1000, 32'h0,      32'h0000_0004, 4'b0001, 32'h0, 32'hFFFF_CDAB};
`else
        vecs[11] = '{1'b0, 3'b010, 32'h0000_0006, 32'h0,        32'h0,        32'h0,       1, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h0,        32'h0, 4'b0000, 32'h0, 32'h0};
        vecs[12] = '{1'b1, 3'b010, 32'hFFFF_FFFE, 32'h1122_3344, 32'h0,        32'h0,       1, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h0,        32'h0, 4'b0000, 32'h0, 32'h0};
        vecs[13] = '{1'b0, 3'b001, 32'h0000_0003, 32'h0,        32'h0,        32'h0,       1, 1'b1, 1'b0, 32'h0,         4'b0000, 32'h0,        32'h0, 4'b0000, 32'h0, 32'h0};
`endif

        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        mem_rdata = '0; mem_resp = 1'b0;
        w_req_valid = 1'b0; w_req_write = 1'b0; w_req_funct3 = '0; w_req_addr = '0; w_req_wdata = '0;
        w_mem_rdata = '0; w_mem_resp = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check("rst_ready_low", req_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ctl", {req_ready, resp_valid, resp_err, mem_read, mem_write, mem_byte_enable}, 9'b1_0000_0000);
        check("post_rst_bus", {resp_rdata, mem_address}, 64'h0);
        check("post_rst_wdata", mem_wdata, 0);

        for (int i = 0; i < NUM_VECS; i++) run_vec(i, vecs[i]);

        // Reset during ACC1: strobes drop, nothing completes, stray mem_resp is ignored.
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0104;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_acc1_read", mem_read, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_ready_held", req_ready, 0);
        rst = 1'b0;
        check("rst_strobe_drop", {mem_read, mem_write, resp_valid}, 3'b000);
        mem_resp = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_resp = 1'b0; mem_rdata = '0;
        check("stray_ignored", {mem_read, mem_write, resp_valid, req_ready}, 4'b0001);
        @(negedge clk);
        check("stray_no_resp", {mem_read, resp_valid, req_ready}, 3'b001);
        $display("txn rst: reset during ACC1 and stray mem_resp");
        run_vec(100, vecs[0]);

        // 64-bit datapath: LD fills all lanes, LW in the upper half sign-extends.
        w_req_valid = 1'b1; w_req_funct3 = 3'b011; w_req_addr = 32'h0000_0010;
        @(negedge clk);
        w_req_valid = 1'b0;
        check("d64_ld_ctl", {w_mem_read, w_mem_write, w_mem_address, w_mem_byte_enable}, {2'b10, 32'h10, 8'hFF});
        w_mem_resp = 1'b1; w_mem_rdata = 64'h8000_0000_0000_0001;
        @(negedge clk);
        w_mem_resp = 1'b0; w_mem_rdata = '0;
        check("d64_ld_resp", {w_resp_valid, w_resp_err}, 2'b10);
        check("d64_ld_data", w_resp_rdata, 64'h8000_0000_0000_0001);
        $display("txn d64 ld: addr=0x10");
        @(negedge clk);
        w_req_valid = 1'b1; w_req_funct3 = 3'b010; w_req_addr = 32'h0000_0014;
        @(negedge clk);
        w_req_valid = 1'b0;
        check("d64_lw_ctl", {w_mem_read, w_mem_address, w_mem_byte_enable}, {1'b1, 32'h10, 8'hF0});
        w_mem_resp = 1'b1; w_mem_rdata = 64'h8000_0000_1234_5678;
        @(negedge clk);
        w_mem_resp = 1'b0; w_mem_rdata = '0;
        check("d64_lw_resp", {w_resp_valid, w_resp_err}, 2'b10);
        check("d64_lw_data", w_resp_rdata, 64'hFFFF_FFFF_8000_0000);
        $display("txn d64 lw: addr=0x14");

        @(negedge clk);
        check("sb_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Parametrised memory-access block for the RV32I-family cores. It replaces the fixed MAR/MDR/MEM_DATA_OUT registers and the per-width load-extension muxing.
- Accepts one load or store request from control/datapath, then drives the memory handshake (mem_read/mem_write/mem_resp).
- Generates byte enables and lane-shifted write data, and returns sign- or zero-extended load data.
- Generalised in data width, and handles accesses that cross a word boundary.

Parameters:
DATA_WIDTH, 32, datapath/memory word width in bits; legal values 32 or 64 (LANES = DATA_WIDTH/8).
ADDR_WIDTH, 32, byte-address width.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V funct3; [1:0] = log2(size in bytes), [2] = unsigned (loads only)
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data, right-aligned
resp_valid  out  1  one-cycle completion pulse
resp_err  out  1  request illegal or misaligned-not-supported, qualified by resp_valid
resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_address  out  ADDR_WIDTH  word-aligned address (low log2(LANES) bits = 0)
mem_byte_enable  out  LANES  active lanes, for both reads and writes
mem_wdata  out  DATA_WIDTH  lane-shifted store data
mem_rdata  in  DATA_WIDTH  read data, valid with mem_resp
mem_resp  in  1  memory completion

Behaviour:
- Handshake and reset outputs:
  - Request is accepted when req_valid && req_ready; all request fields are latched.
  - req_ready = 1 only in IDLE with rst low.
  - While rst is high: req_ready = 0. On the first cycle after rst, all other outputs are 0.
- States:
  - IDLE -> ACC1 on accept of a legal request.
  - IDLE -> DONE on accept of an illegal request.
  - ACC1 -> ACC2 on mem_resp if the access is split; otherwise ACC1 -> DONE on mem_resp.
  - ACC2 -> DONE on mem_resp.
  - DONE -> IDLE unconditionally.
- Outputs by state:
  - mem_read/mem_write asserted throughout ACC1/ACC2.
  - mem_address, mem_byte_enable and mem_wdata are held stable until mem_resp.
  - resp_valid = 1 only in DONE.
- Latency:
  - Accept at cycle T, first mem strobe at T+1.
  - mem_resp at T+k gives resp_valid at T+k+1; minimum 2 cycles.
  - Illegal request gives resp_valid at T+1 with no memory strobe.
- Legality:
  - Illegal if size > LANES bytes, i.e. funct3[1:0] = 3 with DATA_WIDTH = 32.
  - Illegal if a store has funct3[2] = 1.
  - Illegal if a load has funct3 = 3'b111.
  - Illegal requests return resp_err = 1.
- Lanes:
  - off = addr[log2(LANES)-1:0].
  - Byte-enable mask = ((1<<size)-1) << off, computed over 2*LANES bits.
  - Write data = req_wdata << (8*off), computed over 2*DATA_WIDTH bits.
  - The low half of both goes to ACC1, the high half to ACC2.
  - An access is split iff off + size > LANES.
- Load extension:
  - Assembled bytes are taken from (mem_rdata2:mem_rdata1) >> (8*off).
  - Result is truncated to size, then sign-extended (funct3[2] = 0) or zero-extended.
  - ACC1 read data is captured into an internal register on mem_resp.
- Addresses:
  - ACC1 address = addr with the low bits cleared.
  - ACC2 address = ACC1 address + LANES, modulo 2^ADDR_WIDTH (wrap-around).
- Stray responses: mem_resp in IDLE or DONE is ignored.
- Reset mid-operation: rst in any state forces IDLE on the next edge. Strobes drop, no resp_valid is issued, and latched data is discarded.

Optional Feature:
- Macro: LSU_MISALIGNED_SPLIT_EN.
- Defined: a boundary-crossing access is performed as two sequential accesses (ACC1, ACC2) as described above.
- Undefined:
  - ACC2 does not exist.
  - Any access with off + size > LANES is illegal: resp_err = 1 at T+1 with no memory strobe.
  - Naturally aligned and in-word unaligned accesses behave identically to the defined case.

Test Plan:
1. DATA_WIDTH = 32, LB at 0x103, mem_rdata = 0x80FF_1234, mem_resp after 1 cycle -> mem_address = 0x100, mem_byte_enable = 4'b1000, resp_rdata = 0xFFFF_FF80, resp_err = 0. Same with LBU -> 0x0000_0080.
2. SH at 0x202, req_wdata = 0x0000_ABCD -> mem_write = 1, mem_address = 0x200, mem_byte_enable = 4'b1100, mem_wdata[31:16] = 0xABCD, then resp_valid with resp_rdata = 0.
3. With split enabled: LW at 0x006.
   - ACC1: 0x004 with mem_byte_enable 4'b1100; rdata 0x5566_0000.
   - ACC2: 0x008 with mem_byte_enable 4'b0011; rdata 0x0000_7788.
   - Expect resp_rdata = 0x7788_5566.
   - SW at 0xFFFF_FFFE: ACC2 address = 0x0000_0000.
   - Without the macro: LW at 0x006 -> resp_err = 1 at T+1, mem_read never asserted.
4. mem_resp delayed 5 cycles -> mem_read, mem_address and mem_byte_enable stable all 5 cycles; resp_valid high exactly 1 cycle; req_ready = 0 until IDLE.
5. rst pulsed for 1 cycle during ACC1 -> next cycle mem_read = 0, no resp_valid; a subsequent stray mem_resp is ignored; a new request is accepted after rst deasserts.
6. DATA_WIDTH = 32 with funct3 = 3'b011, or a store with funct3 = 3'b100 -> resp_valid and resp_err = 1 at T+1, mem_read = mem_write = 0 throughout. DATA_WIDTH = 64 LD at 0x10 -> mem_byte_enable = 8'hFF.
